// File: rtl/instruction_memory_loader.sv
// Boot loader: byte stream -> little-endian 32-bit words -> instruction RAM writes.
// Define LOADER_CHECKSUM_EN to require a trailing 32-bit sum word after the data.
module instruction_memory_loader #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] wordCount,
  input  logic [7:0]  byteData,
  input  logic        byteValid,
  output logic        byteReady,
  output logic        memWriteEnable,
  output logic [63:0] memWriteAddress,
  output logic [31:0] memWriteData,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_FINISH,
    S_FAIL
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [23:0] part_q, part_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] word_w;
  logic        xfer_w;
  logic [63:0] waddr_w;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic        trl_q, trl_d;
`endif

  assign word_w  = {byteData, part_q};
  assign xfer_w  = byteValid && (state_q == S_COLLECT);
  assign waddr_w = BASE_ADDR + {46'b0, idx_q, 2'b00};

  assign byteReady       = (state_q == S_COLLECT);
  assign memWriteEnable  = (state_q == S_WRITE);
  assign busy            = (state_q == S_COLLECT) || (state_q == S_WRITE);
  assign memWriteAddress = addr_q;
  assign memWriteData    = data_q;
  assign done            = done_q;
  assign error           = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      part_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
      trl_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      part_q  <= part_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      trl_q   <= trl_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    part_d  = part_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = done_q;
    err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    trl_d   = trl_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          cnt_d  = wordCount;
          idx_d  = '0;
          bcnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d  = '0;
          trl_d  = 1'b0;
`endif
          if (wordCount == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            trl_d   = 1'b1;
            state_d = S_COLLECT;
`else
            done_d  = 1'b1;
            state_d = S_FINISH;
`endif
          end else if ({1'b0, wordCount} > MAX_W) begin
            err_d   = 1'b1;
            state_d = S_FAIL;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (xfer_w) begin
          if (bcnt_q == 2'd3) begin
            bcnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
            // Trailer word is compared, never written to RAM
            if (trl_q) begin
              trl_d = 1'b0;
              if (word_w == sum_q) begin
                done_d  = 1'b1;
                state_d = S_FINISH;
              end else begin
                err_d   = 1'b1;
                state_d = S_FAIL;
              end
            end else begin
              addr_d  = waddr_w;
              data_d  = word_w;
              state_d = S_WRITE;
            end
`else
            addr_d  = waddr_w;
            data_d  = word_w;
            state_d = S_WRITE;
`endif
          end else begin
            bcnt_d = bcnt_q + 2'd1;
            unique case (bcnt_q)
              2'd0:    part_d[7:0]   = byteData;
              2'd1:    part_d[15:8]  = byteData;
              default: part_d[23:16] = byteData;
            endcase
          end
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
        sum_d = sum_q + data_q;
`endif
        if (idx_d == cnt_q) begin
`ifdef LOADER_CHECKSUM_EN
          trl_d   = 1'b1;
          state_d = S_COLLECT;
`else
          done_d  = 1'b1;
          state_d = S_FINISH;
`endif
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_FAIL:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader.
// Build with LOADER_CHECKSUM_EN to exercise the trailer path.
module tb_instruction_memory_loader;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] wordCount;
  logic [7:0]  byteData;
  logic        byteValid;
  logic        byteReady;
  logic        memWriteEnable;
  logic [63:0] memWriteAddress;
  logic [31:0] memWriteData;
  logic        busy;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wr_n = 0;
  logic [63:0] wr_addr [64];
  logic [31:0] wr_data [64];
  int          wr_cyc  [64];
  int lastx;

  instruction_memory_loader #(
    .BASE_ADDR(BASE),
    .MAX_WORDS(256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .wordCount(wordCount),
    .byteData(byteData),
    .byteValid(byteValid),
    .byteReady(byteReady),
    .memWriteEnable(memWriteEnable),
    .memWriteAddress(memWriteAddress),
    .memWriteData(memWriteData),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (memWriteEnable && wr_n < 64) begin
      wr_addr[wr_n] = memWriteAddress;
      wr_data[wr_n] = memWriteData;
      wr_cyc[wr_n]  = cyc;
      wr_n++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input logic [15:0] n);
    start = 1'b1;
    wordCount = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byteData = b;
    byteValid = 1'b1;
    while (!byteReady && n < 50) begin
      tick();
      n++;
    end
    chk("byte_timeout", 64'(n < 50), 64'd1);
    tick();
    lastx = cyc;
    byteValid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || error) && n < 50) begin
      tick();
      n++;
    end
    chk("end_timeout", 64'(n < 50), 64'd1);
  endtask

  initial begin
    int w0;
    int xf;
    int n;
    logic bv;
    logic go;
    logic rdy_seen;
    logic [7:0] b4 [4];

    rst = 1'b1;
    start = 1'b0;
    wordCount = '0;
    byteData = '0;
    byteValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(byteReady), 64'd0);
    chk("rst_we", 64'(memWriteEnable), 64'd0);
    chk("rst_addr", memWriteAddress, 64'd0);
    chk("rst_data", 64'(memWriteData), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(error), 64'd0);
    rst = 1'b0;
    tick();

    // Two-word load with a start pulse ignored mid-load
    w0 = wr_n;
    start_pulse(16'd2);
    chk("t1_busy", 64'(busy), 64'd1);
    send_byte(8'h13);
    send_byte(8'h00);
    start_pulse(16'd7);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'hB3);
    send_byte(8'h00);
    send_byte(8'h50);
    send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'h005000C6);
`endif
    wait_end();
    chk("t1_nwr", 64'(wr_n - w0), 64'd2);
    chk("t1_a0", wr_addr[w0], BASE);
    chk("t1_d0", 64'(wr_data[w0]), 64'h13);
    chk("t1_a1", wr_addr[w0+1], BASE + 64'd4);
    chk("t1_d1", 64'(wr_data[w0+1]), 64'h005000B3);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_err", 64'(error), 64'd0);
    chk("t1_busy_end", 64'(busy), 64'd0);
    tick();
    chk("t1_hold_addr", memWriteAddress, BASE + 64'd4);
    chk("t1_hold_data", 64'(memWriteData), 64'h005000B3);

    // Single word, byteValid toggling each cycle
    w0 = wr_n;
    b4[0] = 8'h11; b4[1] = 8'h22; b4[2] = 8'h33; b4[3] = 8'h44;
    start_pulse(16'd1);
    chk("t2_done_clr", 64'(done), 64'd0);
    xf = 0; n = 0; bv = 1'b1;
    while (xf < 4 && n < 40) begin
      byteData = b4[xf];
      byteValid = bv;
      go = bv && byteReady;
      tick();
      if (go) begin
        xf++;
        lastx = cyc;
      end
      bv = ~bv;
      n++;
    end
    byteValid = 1'b0;
    chk("t2_xf", 64'(xf), 64'd4);
`ifdef LOADER_CHECKSUM_EN
    tick();
    send_word(32'h44332211);
`endif
    wait_end();
    chk("t2_nwr", 64'(wr_n - w0), 64'd1);
    chk("t2_lat", 64'(wr_cyc[w0]), 64'(lastx));
    chk("t2_d", 64'(wr_data[w0]), 64'h44332211);
    chk("t2_a", wr_addr[w0], BASE);
    tick();

    // Zero-length load
    w0 = wr_n;
    start_pulse(16'd0);
`ifdef LOADER_CHECKSUM_EN
    chk("t3_ready", 64'(byteReady), 64'd1);
    send_word(32'h0);
    wait_end();
`else
    tick();
`endif
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_err", 64'(error), 64'd0);
    chk("t3_nwr", 64'(wr_n - w0), 64'd0);
    tick();

    // Oversized request
    w0 = wr_n;
    start_pulse(16'd257);
    byteValid = 1'b1;
    rdy_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rdy_seen = rdy_seen | byteReady;
      tick();
    end
    byteValid = 1'b0;
    chk("t4_ready", 64'(rdy_seen), 64'd0);
    chk("t4_err", 64'(error), 64'd1);
    chk("t4_done", 64'(done), 64'd0);
    chk("t4_nwr", 64'(wr_n - w0), 64'd0);

    // Reset mid-load, then restart
    start_pulse(16'd3);
    send_word(32'h01020304);
    send_byte(8'h55);
    send_byte(8'h66);
    rst = 1'b1;
    #1;
    chk("t5_ready", 64'(byteReady), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_addr", memWriteAddress, 64'd0);
    chk("t5_data", 64'(memWriteData), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_err", 64'(error), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    w0 = wr_n;
    start_pulse(16'd1);
    send_word(32'hDDCCBBAA);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'hDDCCBBAA);
`endif
    wait_end();
    chk("t5_nwr", 64'(wr_n - w0), 64'd1);
    chk("t5_d", 64'(wr_data[w0]), 64'hDDCCBBAA);
    chk("t5_a", wr_addr[w0], BASE);
    chk("t5_done2", 64'(done), 64'd1);

`ifdef LOADER_CHECKSUM_EN
    tick();
    w0 = wr_n;
    start_pulse(16'd2);
    send_word(32'h1);
    send_word(32'h2);
    send_word(32'h3);
    wait_end();
    chk("t6_done", 64'(done), 64'd1);
    chk("t6_err", 64'(error), 64'd0);
    chk("t6_nwr", 64'(wr_n - w0), 64'd2);
    tick();
    w0 = wr_n;
    start_pulse(16'd2);
    send_word(32'h1);
    send_word(32'h2);
    send_word(32'h4);
    wait_end();
    chk("t7_err", 64'(error), 64'd1);
    chk("t7_done", 64'(done), 64'd0);
    chk("t7_nwr", 64'(wr_n - w0), 64'd2);
    chk("t7_d1", 64'(wr_data[w0+1]), 64'h2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_memory_loader.md
Name: instruction_memory_loader

Overview:
- Boot-time writer for the writable instruction memory that takes over from the hard-coded NOP ROM.
- Consumes a byte stream (SD/UART front end, valid/ready), assembles little-endian 32-bit instructions and issues one-cycle write strobes at word-aligned addresses.
- Sits between the storage byte source and the instruction RAM write port; the fetch stage reads the same RAM through its own read port.

Parameters:
- BASE_ADDR, 64'h0, byte address of the first instruction written
- MAX_WORDS, 256, capacity of the instruction RAM in 32-bit words; larger load requests are rejected

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a load; ignored while busy
- wordCount  input  16  number of instructions to load, sampled when start is accepted
- byteData  input  8  next byte from the source
- byteValid  input  1  byteData is valid
- byteReady  output  1  loader accepts a byte this cycle (transfer = byteValid & byteReady)
- memWriteEnable  output  1  one-cycle write strobe to instruction RAM
- memWriteAddress  output  64  byte address of the write, always 4-aligned
- memWriteData  output  32  assembled instruction
- busy  output  1  load in progress
- done  output  1  last load completed successfully; held until next accepted start or reset
- error  output  1  last load failed; held until next accepted start or reset

Behaviour:
- Reset (asynchronous, any state): state IDLE; byteReady=0, memWriteEnable=0, memWriteAddress=0, memWriteData=0, busy=0, done=0, error=0. Partial word, byte counter and word index are cleared.
- States: IDLE, COLLECT, WRITE, FINISH, FAIL.
- IDLE + start:
  - Clear done and error, latch wordCount, set word index to 0.
  - If wordCount==0: go to FINISH.
  - Else if wordCount>MAX_WORDS: go to FAIL.
  - Else: go to COLLECT.
- COLLECT:
  - byteReady=1, busy=1.
  - Each transfer places byte k (k=0..3) into bits [8k+7:8k] (little-endian).
  - The transfer of byte 3 moves to WRITE on the next edge.
  - byteValid=0 stalls indefinitely; there is no timeout.
- WRITE (exactly one cycle):
  - byteReady=0, memWriteEnable=1, memWriteAddress=BASE_ADDR+4*index (64-bit, wraps modulo 2^64), memWriteData=assembled word.
  - Then index increments. If index==latched count, go to FINISH; else go to COLLECT.
- Latency: the write strobe comes exactly 1 cycle after the 4th byte transfer. Maximum throughput is one word per 5 cycles.
- FINISH: done=1, busy=0, go to IDLE (done stays held).
- FAIL: error=1, busy=0, go to IDLE (error stays held).
- When memWriteEnable=0, memWriteAddress and memWriteData hold their last values.
- start while busy: ignored, with no effect on the count or outputs.
- start in the same cycle as the final WRITE: ignored.
- start in a later IDLE cycle: accepted.
- Bytes presented while byteReady=0 are not consumed; the source must hold them.
- done and error are never 1 at the same time.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - The loader keeps a 32-bit running sum (modulo 2^32) of every written word.
  - After the last WRITE it collects one more 4-byte little-endian trailer word in COLLECT without issuing a write.
  - Trailer == sum: go to FINISH. Mismatch: go to FAIL.
  - A wordCount==0 request still expects a trailer, which must equal 32'h0.
- Not defined:
  - No trailer and no adder logic.
  - The only FAIL cause is wordCount>MAX_WORDS.

Test Plan:
- Reset, then start with wordCount=2 and bytes 13 00 00 00 B3 00 50 00:
  - Writes 32'h00000013 @BASE_ADDR+0, then 32'h005000B3 @BASE_ADDR+4.
  - done=1, error=0, busy=0.
- Single-word load with byteValid toggled 1/0 each cycle: the write happens exactly 1 cycle after the 4th accepted byte; no write occurs during stalls.
- wordCount=0: done=1 within 2 cycles and no memWriteEnable (checksum build: trailer 00 00 00 00 is required first).
- wordCount=257 with MAX_WORDS=256: error=1, byteReady never asserts, no writes.
- Assert rst after 2 bytes of word 1 of a 3-word load: all outputs return to 0 immediately. Restart with wordCount=1 and bytes AA BB CC DD: one write of 32'hDDCCBBAA @BASE_ADDR.
- LOADER_CHECKSUM_EN, words 32'h1 and 32'h2:
  - Trailer 03 00 00 00: done=1.
  - Trailer 04 00 00 00: error=1 and done=0. Both data writes still occurred.
